// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer stimulus stage.
package reaction_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StLed   = 2'd2,
    StFalse = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;
  localparam int unsigned TIMEOUT_MS        = 4095;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/reaction_stimulus_gen_if.sv
// Handshake bundle between the stimulus stage and its neighbours.
// REACTION_STIM_TIMEOUT_EN adds the timeout strobe.
interface reaction_stimulus_gen_if;
  logic start;
  logic button;
  logic led_on;
  logic led_rise;
  logic busy;
  logic false_start;
`ifdef REACTION_STIM_TIMEOUT_EN
  logic timeout;

  modport master (
    output start, button,
    input  led_on, led_rise, busy, false_start, timeout
  );
  modport slave (
    input  start, button,
    output led_on, led_rise, busy, false_start, timeout
  );
`else
  modport master (
    output start, button,
    input  led_on, led_rise, busy, false_start
  );
  modport slave (
    input  start, button,
    output led_on, led_rise, busy, false_start
  );
`endif
endinterface

// File: rtl/reaction_lfsr.sv
// Free-running 16-bit Galois LFSR; recovers from the all-zero state by reloading the seed.
module reaction_lfsr
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED  = DEFAULT_LFSR_SEED,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [OUT_W-1:0] value
);

  logic [15:0] lfsr_q, lfsr_d;

  // Next value: advance when enabled, escape the lock-up state.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = (lfsr_q == 16'h0000) ? SEED : lfsr_next(lfsr_q);
    end
  end

  // State register with synchronous reset to the seed.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/reaction_stimulus_gen.sv
// Reaction-timer stimulus: random delay after start, then LED until press.
// REACTION_STIM_TIMEOUT_EN: abandon an unanswered LED after TIMEOUT_MS ms.
module reaction_stimulus_gen
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 10000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 11,
  parameter logic [15:0] LFSR_SEED    = DEFAULT_LFSR_SEED
) (
  input logic                     clk,
  input logic                     rst,
  reaction_stimulus_gen_if.slave  bus
);

  localparam int unsigned DCW = $clog2(MIN_DELAY_MS + 2 ** RAND_BITS);
  localparam int unsigned PW  = $clog2(TICK_DIV);

  state_e               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [DCW-1:0]       delay_q, delay_d;
  logic                 led_on_q, led_on_d;
  logic                 led_rise_q, led_rise_d;
  logic                 busy_q, busy_d;
  logic                 fs_q, fs_d;
  logic [RAND_BITS-1:0] rand_val;
  logic                 ms_tick;
`ifdef REACTION_STIM_TIMEOUT_EN
  logic [11:0]          to_cnt_q, to_cnt_d;
  logic                 timeout_q, timeout_d;
`endif

  reaction_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (RAND_BITS)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .value (rand_val)
  );

  assign ms_tick = (presc_q == PW'(TICK_DIV - 1));

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    fs_d    = fs_q;
    presc_d = ms_tick ? '0 : presc_q + PW'(1);
`ifdef REACTION_STIM_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      StIdle, StFalse: begin
        if (bus.start) begin
          if (bus.button) begin
            state_d = StFalse;
            fs_d    = 1'b1;
          end else begin
            // Delay uses the LFSR value present in the start cycle.
            delay_d = DCW'(MIN_DELAY_MS) + DCW'(rand_val);
            fs_d    = 1'b0;
            presc_d = '0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // A press beats a coincident tick.
        if (bus.button) begin
          state_d = StFalse;
          fs_d    = 1'b1;
        end else if (ms_tick) begin
          if (delay_q == DCW'(1)) begin
            state_d = StLed;
`ifdef REACTION_STIM_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end else begin
            delay_d = delay_q - DCW'(1);
          end
        end
      end
      StLed: begin
        if (bus.button) begin
          state_d = StIdle;
        end
`ifdef REACTION_STIM_TIMEOUT_EN
        else if (ms_tick) begin
          if (to_cnt_q == 12'(TIMEOUT_MS - 1)) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 12'd1;
          end
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    led_on_d   = (state_d == StLed);
    busy_d     = (state_d == StWait) || (state_d == StLed);
    led_rise_d = (state_d == StLed) && (state_q != StLed);
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      delay_q    <= '0;
      led_on_q   <= 1'b0;
      led_rise_q <= 1'b0;
      busy_q     <= 1'b0;
      fs_q       <= 1'b0;
`ifdef REACTION_STIM_TIMEOUT_EN
      to_cnt_q   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      delay_q    <= delay_d;
      led_on_q   <= led_on_d;
      led_rise_q <= led_rise_d;
      busy_q     <= busy_d;
      fs_q       <= fs_d;
`ifdef REACTION_STIM_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign bus.led_on      = led_on_q;
  assign bus.led_rise    = led_rise_q;
  assign bus.busy        = busy_q;
  assign bus.false_start = fs_q;
`ifdef REACTION_STIM_TIMEOUT_EN
  assign bus.timeout     = timeout_q;
`endif

endmodule
